regfile_mp: RTL and testbench

- Parametrised multi-port register file for the accelerator datapath; successor to the single-write 8x8 register file.
- Configurable width and depth; two read ports and two write ports.
- Optional same-cycle write-to-read bypass and optional hardwired-zero register 0.
- Per-register pending scoreboard: the issue stage marks a destination as in flight, and readiness is reported per read port.

---
 rtl/regfile_mp.sv | 144 ++++++++++++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
// regfile_mp
// Parametrised register file for the accelerator datapath. It has two
// combinational read ports (S, T) and two write ports (A, B), plus a
// per-register pending scoreboard that the issue stage drives.
//
// Ports:
//   clock        sole clock, every state update happens on its rising edge
//   reset        synchronous active-low reset, sampled on the rising edge
//   rs_num/rt_num        read port S/T register index
//   rs_data/rt_data      read port S/T data (combinational)
//   rs_ready/rt_ready    read port S/T value is valid (not pending or bypassed)
//   wa_en/wa_num/wa_data write port A enable, index, data
//   wb_en/wb_num/wb_data write port B enable, index, data (wins over A)
//   mark_en/mark_num     mark a register as an in-flight destination
//   pending_vec          current pending bits, bit i = register i
//
// Parameters:
//   DATA_W    register width
//   DEPTH     number of registers (power of two, >= 2)
//   ADDR_W    log2(DEPTH)
//   BYPASS    1 = forward same-cycle writes to matching read ports
//   ZERO_REG  1 = register 0 reads as zero, ignores writes, never pending

module regfile_mp #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_num,
    input  logic [ADDR_W-1:0] rt_num,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_ready,
    output logic              rt_ready,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_num,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_num,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_num,
    output logic [DEPTH-1:0]  pending_vec
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pendingNext;

    logic waEff;
    logic wbEff;
    logic markEff;
    logic bypassOn;

    // With a hardwired zero register, any write or mark aimed at index 0 is
    // squashed here, so the storage and scoreboard never see it.
    always_comb begin
        waEff   = wa_en;
        wbEff   = wb_en;
        markEff = mark_en;
        if (ZERO_REG != 0) begin
            if (wa_num == '0)   waEff   = 1'b0;
            if (wb_num == '0)   wbEff   = 1'b0;
            if (mark_num == '0) markEff = 1'b0;
        end
    end

    // Forwarding is only meaningful while out of reset, because the writes
    // presented during a reset cycle will be thrown away at the edge.
    always_comb begin
        bypassOn = (BYPASS != 0) && reset;
    end

    // Scoreboard next state. A mark beats a write to the same register: the
    // write retires an older producer while the mark announces a newer one,
    // so the register must stay pending.
    always_comb begin
        pendingNext = pending;
        for (int i = 0; i < DEPTH; i++) begin
            if (markEff && (mark_num == ADDR_W'(i))) begin
                pendingNext[i] = 1'b1;
            end else if ((waEff && (wa_num == ADDR_W'(i))) ||
                         (wbEff && (wb_num == ADDR_W'(i)))) begin
                pendingNext[i] = 1'b0;
            end
        end
    end

    // Storage and scoreboard registers. Port B is written after port A so
    // that, on an index collision, B's data is the one that lands.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (waEff) regs[wa_num] <= wa_data;
            if (wbEff) regs[wb_num] <= wb_data;
            pending <= pendingNext;
        end
    end

    // Read port S: zero register first, then forwarded write B, then A,
    // then the stored value gated by the scoreboard.
    always_comb begin
        rs_data  = regs[rs_num];
        rs_ready = !pending[rs_num];
        if ((ZERO_REG != 0) && (rs_num == '0)) begin
            rs_data  = '0;
            rs_ready = 1'b1;
        end else if (bypassOn && wbEff && (wb_num == rs_num)) begin
            rs_data  = wb_data;
            rs_ready = 1'b1;
        end else if (bypassOn && waEff && (wa_num == rs_num)) begin
            rs_data  = wa_data;
            rs_ready = 1'b1;
        end
    end

    // Read port T: same priority as port S.
    always_comb begin
        rt_data  = regs[rt_num];
        rt_ready = !pending[rt_num];
        if ((ZERO_REG != 0) && (rt_num == '0)) begin
            rt_data  = '0;
            rt_ready = 1'b1;
        end else if (bypassOn && wbEff && (wb_num == rt_num)) begin
            rt_data  = wb_data;
            rt_ready = 1'b1;
        end else if (bypassOn && waEff && (wa_num == rt_num)) begin
            rt_data  = wa_data;
            rt_ready = 1'b1;
        end
    end

    assign pending_vec = pending;

endmodule

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
// tb_regfile_mp
// Directed bench for regfile_mp. Three instances share one set of inputs:
//   dutA  BYPASS=1 ZERO_REG=0 (default configuration)
//   dutB  BYPASS=0 ZERO_REG=0 (no forwarding)
//   dutZ  BYPASS=1 ZERO_REG=1 (hardwired zero register)
// Expected values are hand-computed constants.

module tb_regfile_mp;

    logic       clock;
    logic       reset;
    logic [2:0] rsNum, rtNum;
    logic       waEn, wbEn, markEn;
    logic [2:0] waNum, wbNum, markNum;
    logic [7:0] waData, wbData;

    logic [7:0] aRsData, aRtData, bRsData, bRtData, zRsData, zRtData;
    logic       aRsReady, aRtReady, bRsReady, bRtReady, zRsReady, zRtReady;
    logic [7:0] aPending, bPending, zPending;

    int testsRun;
    int testsFailed;

    regfile_mp #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dutA (
        .clock(clock), .reset(reset),
        .rs_num(rsNum), .rt_num(rtNum),
        .rs_data(aRsData), .rt_data(aRtData),
        .rs_ready(aRsReady), .rt_ready(aRtReady),
        .wa_en(waEn), .wa_num(waNum), .wa_data(waData),
        .wb_en(wbEn), .wb_num(wbNum), .wb_data(wbData),
        .mark_en(markEn), .mark_num(markNum),
        .pending_vec(aPending)
    );

    regfile_mp #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dutB (
        .clock(clock), .reset(reset),
        .rs_num(rsNum), .rt_num(rtNum),
        .rs_data(bRsData), .rt_data(bRtData),
        .rs_ready(bRsReady), .rt_ready(bRtReady),
        .wa_en(waEn), .wa_num(waNum), .wa_data(waData),
        .wb_en(wbEn), .wb_num(wbNum), .wb_data(wbData),
        .mark_en(markEn), .mark_num(markNum),
        .pending_vec(bPending)
    );

    regfile_mp #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dutZ (
        .clock(clock), .reset(reset),
        .rs_num(rsNum), .rt_num(rtNum),
        .rs_data(zRsData), .rt_data(zRtData),
        .rs_ready(zRsReady), .rt_ready(zRtReady),
        .wa_en(waEn), .wa_num(waNum), .wa_data(waData),
        .wb_en(wbEn), .wb_num(wbNum), .wb_data(wbData),
        .mark_en(markEn), .mark_num(markNum),
        .pending_vec(zPending)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle's worth of write/mark inputs and let the
    // combinational read path settle (no clock edge here).
    task automatic applyStimulus(
        input logic       wae, input logic [2:0] wan, input logic [7:0] wad,
        input logic       wbe, input logic [2:0] wbn, input logic [7:0] wbd,
        input logic       me,  input logic [2:0] mn
    );
        waEn = wae; waNum = wan; waData = wad;
        wbEn = wbe; wbNum = wbn; wbData = wbd;
        markEn = me; markNum = mn;
        #1;
    endtask

    // Advance through one rising edge and sample 1 ns after it.
    task automatic clockEdge();
        @(posedge clock);
        #1;
    endtask

    // Compare one observed value against its expected constant.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence; every step is followed by its checks.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rsNum = 3'd0;
        rtNum = 3'd0;
        reset = 1'b0;

        // Reset held two edges while a write and a mark to r3 are presented.
        rsNum = 3'd3;
        applyStimulus(1'b1, 3'd3, 8'hAA, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
        clockEdge();
        checkOutput("bypassSuppressedInReset", aRsData, 8'h00);
        clockEdge();
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        checkOutput("resetRsData", aRsData, 8'h00);
        checkOutput("resetRsReady", aRsReady, 1'b1);
        checkOutput("resetRtReady", aRtReady, 1'b1);
        checkOutput("resetPendingA", aPending, 8'h00);
        checkOutput("resetPendingB", bPending, 8'h00);
        checkOutput("resetPendingZ", zPending, 8'h00);

        // Dual write to distinct registers.
        applyStimulus(1'b1, 3'd2, 8'h11, 1'b1, 3'd5, 8'h22, 1'b0, 3'd0);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        rsNum = 3'd2;
        rtNum = 3'd5;
        #1;
        checkOutput("dualWriteR2", aRsData, 8'h11);
        checkOutput("dualWriteR5", aRtData, 8'h22);
        checkOutput("dualWriteR2NoBypass", bRsData, 8'h11);

        // Both ports on r4: port B wins.
        applyStimulus(1'b1, 3'd4, 8'h33, 1'b1, 3'd4, 8'h44, 1'b0, 3'd0);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        rsNum = 3'd4;
        #1;
        checkOutput("conflictR4", aRsData, 8'h44);

        // Same-cycle write to r6 read on port S: forwarded only with BYPASS.
        rsNum = 3'd6;
        applyStimulus(1'b1, 3'd6, 8'h5C, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        checkOutput("bypassR6", aRsData, 8'h5C);
        checkOutput("noBypassR6Old", bRsData, 8'h00);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        checkOutput("noBypassR6After", bRsData, 8'h5C);

        // Both write ports hit rt's index: forwarded value is port B's.
        rtNum = 3'd6;
        applyStimulus(1'b1, 3'd6, 8'h01, 1'b1, 3'd6, 8'h02, 1'b0, 3'd0);
        checkOutput("bypassPriorityB", aRtData, 8'h02);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        checkOutput("storedPriorityB", bRtData, 8'h02);

        // Mark r7 pending.
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        rsNum = 3'd7;
        #1;
        checkOutput("markPending7", aPending, 8'h80);
        checkOutput("markRsReady", aRsReady, 1'b0);
        checkOutput("markRsReadyNoBypass", bRsReady, 1'b0);
        checkOutput("markRtReadyOther", aRtReady, 1'b1);

        // Port B write to r7 retires it; bypass makes it ready immediately.
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h9E, 1'b0, 3'd0);
        checkOutput("writeCycleReady", aRsReady, 1'b1);
        checkOutput("writeCycleData", aRsData, 8'h9E);
        checkOutput("writeCycleReadyNoBypass", bRsReady, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        checkOutput("retiredPending", aPending, 8'h00);
        checkOutput("retiredData", aRsData, 8'h9E);
        checkOutput("retiredReadyNoBypass", bRsReady, 1'b1);

        // Mark and write on r1 in the same cycle: data lands, stays pending.
        applyStimulus(1'b1, 3'd1, 8'h0F, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        rsNum = 3'd1;
        #1;
        checkOutput("collideData", aRsData, 8'h0F);
        checkOutput("collidePending", aPending, 8'h02);
        checkOutput("collideReady", aRsReady, 1'b0);

        // Write FF to index 0 and mark it: only dutZ ignores both.
        rtNum = 3'd0;
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
        checkOutput("zeroNoBypass", zRtData, 8'h00);
        checkOutput("zeroReadyDuring", zRtReady, 1'b1);
        checkOutput("normalBypassR0", aRtData, 8'hFF);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        checkOutput("zeroData", zRtData, 8'h00);
        checkOutput("zeroReady", zRtReady, 1'b1);
        checkOutput("zeroPending", zPending, 8'h02);
        checkOutput("normalR0Data", aRtData, 8'hFF);
        checkOutput("normalR0Pending", aPending, 8'h03);

        // Mark r3, then reset mid-operation with a write in flight.
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        checkOutput("midPendingBefore", aPending, 8'h0B);
        reset = 1'b0;
        rsNum = 3'd5;
        applyStimulus(1'b1, 3'd5, 8'h77, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6);
        clockEdge();
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        checkOutput("midResetPendingA", aPending, 8'h00);
        checkOutput("midResetPendingZ", zPending, 8'h00);
        checkOutput("midResetR5", aRsData, 8'h00);
        checkOutput("midResetR0", aRtData, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
